// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Watches a multiplexed 7-segment bus and recovers the hex value that is
//   shown on each digit. A pattern is accepted only after it has been
//   sampled unchanged for STABLE_CYCLES consecutive cycles. Patterns that
//   are not legal glyphs are flagged.
//
//   Build option: define SEG_ACTIVE_LOW_EN for common-anode boards. The seg
//   input is then inverted at the input stage, and err_pattern holds the
//   inverted (active-high) pattern.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (deassert synchronised inside)
//   seg[6:0]     segment pattern: bit6=A .. bit0=G
//   digit_sel    one-hot digit enable; bit i selects digit i
//   number       decoded values; digit i occupies bits [4i+3:4i]
//   digit_valid  digit i holds a legally decoded value
//   update       one-cycle pulse when any digit slot is written
//   err          one-cycle pulse on capture of an illegal pattern
//   err_pattern  last illegal pattern captured
module seven_segment_decoder #(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] number,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    err,
  output logic [6:0]              err_pattern
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HELD} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  // Reset: asserts immediately, releases on the second clock edge.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i = rst_sync[1];

  // Input polarity
  logic [6:0] seg_in;
`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~seg;
`else
  assign seg_in = seg;
`endif

  // Glyph decode: {legal, value}
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E:   r = {1'b1, 4'h0};
      7'h30:   r = {1'b1, 4'h1};
      7'h6D:   r = {1'b1, 4'h2};
      7'h79:   r = {1'b1, 4'h3};
      7'h33:   r = {1'b1, 4'h4};
      7'h5B:   r = {1'b1, 4'h5};
      7'h5F:   r = {1'b1, 4'h6};
      7'h70:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h7B:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h1F:   r = {1'b1, 4'hB};
      7'h4E:   r = {1'b1, 4'hC};
      7'h3D:   r = {1'b1, 4'hD};
      7'h4F:   r = {1'b1, 4'hE};
      7'h47:   r = {1'b1, 4'hF};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t                  state;
  logic [6:0]              s_seg;
  logic [NUM_DIGITS-1:0]   s_sel;
  logic [7:0]              cnt;

  // Last captured sample. A glitch that returns to the already-captured
  // pattern re-settles, but it must not produce a second write.
  logic [6:0]              cap_seg;
  logic [NUM_DIGITS-1:0]   cap_sel;
  logic                    cap_vld;

  logic       chg;
  logic       sel_ok;
  logic       same_as_cap;
  logic [4:0] dec;

  always_comb begin
    chg         = (seg_in != s_seg) || (digit_sel != s_sel);
    sel_ok      = $onehot(digit_sel);
    same_as_cap = cap_vld && (s_seg == cap_seg) && (s_sel == cap_sel);
    dec         = decode(s_seg);
  end

  // The capture decision is made on the edge where the sample has been seen
  // unchanged STABLE_CYCLES times. The write and the update pulse are
  // registered on that same edge, and the CAPTURE state marks the pulse
  // cycle.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      s_seg       <= '0;
      s_sel       <= '0;
      cnt         <= '0;
      cap_seg     <= '0;
      cap_sel     <= '0;
      cap_vld     <= 1'b0;
      number      <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      err         <= 1'b0;
      err_pattern <= '0;
    end else begin
      s_seg  <= seg_in;
      s_sel  <= digit_sel;
      update <= 1'b0;
      err    <= 1'b0;
      if (!sel_ok) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (chg) begin
        cnt   <= '0;
        state <= SETTLE;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        unique case (state)
          IDLE:    state <= SETTLE;
          SETTLE: begin
            if (cnt == CNT_HIT) begin
              if (same_as_cap) begin
                state <= HELD;
              end else begin
                state   <= CAPTURE;
                update  <= 1'b1;
                cap_seg <= s_seg;
                cap_sel <= s_sel;
                cap_vld <= 1'b1;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                  if (s_sel[i]) begin
                    digit_valid[i] <= dec[4];
                    if (dec[4]) number[4*i +: 4] <= dec[3:0];
                  end
                end
                if (!dec[4] && (s_seg != '0)) begin
                  err         <= 1'b1;
                  err_pattern <= s_seg;
                end
              end
            end
          end
          CAPTURE: state <= HELD;
          HELD:    state <= HELD;
        endcase
      end
    end
  end

endmodule
